ray_setup_recip: RTL and testbench

- Ray-setup stage directly upstream of the AABB slab-test pipeline.
- Accepts one ray (origin, direction, tag) per transaction and computes the per-axis inverse direction in Q16.16 using three parallel restoring dividers.
- Presents origin, inv_dir and tag to the intersector with a valid/ready handshake, so the slab test never divides.

---
 rtl/ray_setup_recip_if.sv | 43 ++++
 rtl/ray_setup_recip.sv | 198 +++++++++++++++++++
 tb/tb_ray_setup_recip.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ray_setup_recip_if.sv
// Ray-setup handshake bundle.
// Upstream side: in_valid/in_ready with tag, origin and direction (Q16.16 signed).
// Downstream side: out_valid/out_ready with tag, origin, inverse direction and
// per-axis zero/saturation flags.
// The block itself uses the slave modport; the environment uses the master modport.
interface ray_setup_recip_if #(
  parameter int W     = 32,
  parameter int TAG_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic        [TAG_W-1:0] in_tag;
  logic signed [W-1:0]     in_ox;
  logic signed [W-1:0]     in_oy;
  logic signed [W-1:0]     in_oz;
  logic signed [W-1:0]     in_dx;
  logic signed [W-1:0]     in_dy;
  logic signed [W-1:0]     in_dz;

  logic                    out_valid;
  logic                    out_ready;
  logic        [TAG_W-1:0] out_tag;
  logic signed [W-1:0]     out_ox;
  logic signed [W-1:0]     out_oy;
  logic signed [W-1:0]     out_oz;
  logic signed [W-1:0]     out_inv_dx;
  logic signed [W-1:0]     out_inv_dy;
  logic signed [W-1:0]     out_inv_dz;
  logic        [2:0]       out_zero;
  logic        [2:0]       out_sat;

  modport master (
    output in_valid, in_tag, in_ox, in_oy, in_oz, in_dx, in_dy, in_dz, out_ready,
    input  in_ready, out_valid, out_tag, out_ox, out_oy, out_oz,
           out_inv_dx, out_inv_dy, out_inv_dz, out_zero, out_sat
  );

  modport slave (
    input  in_valid, in_tag, in_ox, in_oy, in_oz, in_dx, in_dy, in_dz, out_ready,
    output in_ready, out_valid, out_tag, out_ox, out_oy, out_oz,
           out_inv_dx, out_inv_dy, out_inv_dz, out_zero, out_sat
  );
endinterface

// File: rtl/ray_setup_recip.sv
// Ray setup ahead of the AABB slab test.
// Takes one ray (tag, origin, direction) per transaction and produces the
// per-axis reciprocal of the direction in Q16.16, so the slab test only multiplies.
// Three restoring dividers (one per axis) run in lockstep, one quotient bit per
// cycle, 33 iterations for floor(2^32 / |d|).
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset; discards any ray in flight
//   rs    - ray_setup_recip_if.slave: in_* ray input with in_valid/in_ready,
//           out_* result with out_valid/out_ready, out_zero/out_sat flags
//           (bit0=x, bit1=y, bit2=z)
module ray_setup_recip #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ray_setup_recip_if.slave    rs
);

  localparam int           QW      = W + 1;
  localparam logic [5:0]   LAST_IT = 6'(2 * FRAC);
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

  // Unsigned magnitude; the most negative value wraps to 2^(W-1), which is
  // exactly its magnitude when read as unsigned.
  function automatic logic [W-1:0] mag_of(input logic signed [W-1:0] d);
    logic [W-1:0] u;
    u = d;
    return d[W-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic recip_sat(input logic [QW-1:0] q, input logic zero);
    return zero || (q > {1'b0, MAX_POS});
  endfunction

  // Clamp the magnitude first, then apply the sign, so negative saturation
  // lands on -MAX_POS rather than the most negative code.
  function automatic logic signed [W-1:0] recip_value(input logic [QW-1:0] q,
                                                      input logic zero,
                                                      input logic neg);
    logic [W-1:0] m;
    m = recip_sat(q, zero) ? MAX_POS : q[W-1:0];
    return neg ? $signed(~m + 1'b1) : $signed(m);
  endfunction

  state_t state_q, state_d;
  logic [5:0] iter_q;
  logic       out_valid_q;
  logic       accept, last, release_hold;

  logic signed [W-1:0] in_d [3];

  logic        [TAG_W-1:0] tag_p0;
  logic signed [W-1:0]     ox_p0, oy_p0, oz_p0;
  logic        [W-1:0]     n_p0 [3];
  logic        [2:0]       neg_p0;
  logic        [2:0]       zero_p0;

  logic [W-1:0]  rem_p1 [3];
  logic [W-1:0]  quo_p1 [3];
  logic [W:0]    trial  [3];
  logic          ge     [3];
  logic [W-1:0]  rem_d  [3];
  logic [QW-1:0] quo_d  [3];

  logic signed [W-1:0] inv_p2 [3];
  logic        [2:0]   zero_p2;
  logic        [2:0]   sat_p2;

  assign in_d[0] = rs.in_dx;
  assign in_d[1] = rs.in_dy;
  assign in_d[2] = rs.in_dz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        iter_q <= '0;
      end else if (state_q == DIV) begin
        iter_q <= iter_q + 1'b1;
      end
      if (last) begin
        out_valid_q <= 1'b1;
      end else if (release_hold) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    last         = 1'b0;
    release_hold = 1'b0;
    case (state_q)
      IDLE: begin
        if (rs.in_valid) begin
          accept  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        if (iter_q == LAST_IT) begin
          last    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rs.out_ready) begin
          release_hold = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Restoring step: the dividend 2^32 contributes a single 1 on the first
  // iteration and zeros afterwards. The remainder stays below |d| <= 2^31.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      trial[a] = {rem_p1[a], iter_q == 6'd0};
      ge[a]    = trial[a] >= {1'b0, n_p0[a]};
      rem_d[a] = ge[a] ? W'(trial[a] - {1'b0, n_p0[a]}) : trial[a][W-1:0];
      quo_d[a] = {quo_p1[a], ge[a]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_p0  <= '0;
      ox_p0   <= '0;
      oy_p0   <= '0;
      oz_p0   <= '0;
      neg_p0  <= '0;
      zero_p0 <= '0;
      zero_p2 <= '0;
      sat_p2  <= '0;
      for (int a = 0; a < 3; a++) begin
        n_p0[a]   <= '0;
        rem_p1[a] <= '0;
        quo_p1[a] <= '0;
        inv_p2[a] <= '0;
      end
    end else begin
      // p0: capture ray on accept
      if (accept) begin
        tag_p0 <= rs.in_tag;
        ox_p0  <= rs.in_ox;
        oy_p0  <= rs.in_oy;
        oz_p0  <= rs.in_oz;
        for (int a = 0; a < 3; a++) begin
          n_p0[a]    <= mag_of(in_d[a]);
          neg_p0[a]  <= in_d[a][W-1];
          zero_p0[a] <= (in_d[a] == '0);
          rem_p1[a]  <= '0;
          quo_p1[a]  <= '0;
        end
      end
      // p1: one quotient bit per axis per cycle
      if (state_q == DIV) begin
        for (int a = 0; a < 3; a++) begin
          rem_p1[a] <= rem_d[a];
          quo_p1[a] <= quo_d[a][W-1:0];
        end
      end
      // p2: saturate, sign and register the result on the final iteration
      if (last) begin
        zero_p2 <= zero_p0;
        for (int a = 0; a < 3; a++) begin
          inv_p2[a] <= recip_value(quo_d[a], zero_p0[a], neg_p0[a]);
          sat_p2[a] <= recip_sat(quo_d[a], zero_p0[a]);
        end
      end
    end
  end

  assign rs.in_ready   = (state_q == IDLE);
  assign rs.out_valid  = out_valid_q;
  assign rs.out_tag    = tag_p0;
  assign rs.out_ox     = ox_p0;
  assign rs.out_oy     = oy_p0;
  assign rs.out_oz     = oz_p0;
  assign rs.out_inv_dx = inv_p2[0];
  assign rs.out_inv_dy = inv_p2[1];
  assign rs.out_inv_dz = inv_p2[2];
  assign rs.out_zero   = zero_p2;
  assign rs.out_sat    = sat_p2;

endmodule

// File: tb/tb_ray_setup_recip.sv
module tb_ray_setup_recip;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ray_setup_recip_if #(.W(32), .TAG_W(8)) rif();

  ray_setup_recip #(.W(32), .FRAC(16), .TAG_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs    (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a ray for one cycle; returns 1 ns after the accept edge.
  task automatic drive_ray(input logic [7:0] tag,
                           input logic [31:0] ox, input logic [31:0] oy, input logic [31:0] oz,
                           input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dz);
    @(negedge clk);
    rif.in_valid = 1'b1;
    rif.in_tag   = tag;
    rif.in_ox    = ox;
    rif.in_oy    = oy;
    rif.in_oz    = oz;
    rif.in_dx    = dx;
    rif.in_dy    = dy;
    rif.in_dz    = dz;
    @(posedge clk);
    #1;
    rif.in_valid = 1'b0;
  endtask

  // Returns the number of edges after the accept edge at which downstream
  // first samples out_valid high, or -1 if it never rises within the budget.
  task automatic wait_valid(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (rif.out_valid === 1'b1) begin
        lat  = i + 1;
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rif.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset in_ready: got %b want 1", rif.in_ready);
    end
    n_cmp++;
    if (rif.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset out_valid: got %b want 0", rif.out_valid);
    end
    n_cmp++;
    if ({rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz, rif.out_ox, rif.out_oy, rif.out_oz,
         rif.out_tag, rif.out_zero, rif.out_sat} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got inv %h %h %h tag %h zero %b sat %b want all 0",
               rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz, rif.out_tag, rif.out_zero, rif.out_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    int lat;
    rif.out_ready = 1'b1;
    drive_ray(8'h5A, 32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0003_0000);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 34) begin
      n_bad++;
      $display("FAIL nominal latency: got %0d want 34", lat);
    end
    n_cmp++;
    if ({rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz} !== {32'h0001_0000, 32'h0002_0000, 32'h0000_5555}) begin
      n_bad++;
      $display("FAIL nominal inv: got %h %h %h want 00010000 00020000 00005555",
               rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz);
    end
    n_cmp++;
    if ({rif.out_tag, rif.out_zero, rif.out_sat} !== {8'h5A, 3'b000, 3'b000}) begin
      n_bad++;
      $display("FAIL nominal tag/flags: got %h %b %b want 5a 000 000", rif.out_tag, rif.out_zero, rif.out_sat);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rif.out_valid, rif.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL nominal handshake: got valid %b ready %b want 0 1", rif.out_valid, rif.in_ready);
    end
  endtask

  task automatic test_signs;
    int lat;
    rif.out_ready = 1'b1;
    drive_ray(8'hC3, 32'h0001_1000, 32'hFFFE_0000, 32'h1234_5678,
              32'hFFFF_0000, 32'h8000_0000, 32'h0002_0000);
    wait_valid(lat);
    n_cmp++;
    if ({rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz} !== {32'hFFFF_0000, 32'hFFFF_FFFE, 32'h0000_8000}) begin
      n_bad++;
      $display("FAIL signs inv: got %h %h %h want ffff0000 fffffffe 00008000",
               rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz);
    end
    n_cmp++;
    if ({rif.out_zero, rif.out_sat} !== 6'b000_000) begin
      n_bad++;
      $display("FAIL signs flags: got zero %b sat %b want 000 000", rif.out_zero, rif.out_sat);
    end
    n_cmp++;
    if ({rif.out_tag, rif.out_ox, rif.out_oy, rif.out_oz} !== {8'hC3, 32'h0001_1000, 32'hFFFE_0000, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL signs origin/tag: got %h %h %h %h want c3 00011000 fffe0000 12345678",
               rif.out_tag, rif.out_ox, rif.out_oy, rif.out_oz);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_degenerate;
    int lat;
    rif.out_ready = 1'b1;
    drive_ray(8'h3C, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFF);
    wait_valid(lat);
    n_cmp++;
    if ({rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz} !== {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0001}) begin
      n_bad++;
      $display("FAIL degenerate inv: got %h %h %h want 7fffffff 7fffffff 80000001",
               rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz);
    end
    n_cmp++;
    if (rif.out_zero !== 3'b001) begin
      n_bad++;
      $display("FAIL degenerate zero: got %b want 001", rif.out_zero);
    end
    n_cmp++;
    if (rif.out_sat !== 3'b111) begin
      n_bad++;
      $display("FAIL degenerate sat: got %b want 111", rif.out_sat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int lat;
    rif.out_ready = 1'b0;
    // 2^32/2^18 = 0x4000; |-2^17| -> 0x8000 negated; 2^32/3 = 0x55555555
    drive_ray(8'h11, 32'h1, 32'h2, 32'h3, 32'h0004_0000, 32'hFFFE_0000, 32'h0000_0003);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 34) begin
      n_bad++;
      $display("FAIL backpressure latency: got %0d want 34", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rif.in_valid = 1'b1;
      rif.in_tag   = 8'(i + 8'h80);
      rif.in_ox    = 32'(i * 7);
      rif.in_dx    = 32'(i + 1);
      rif.in_dy    = 32'h0;
      rif.in_dz    = 32'(32'h1000 << i);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({rif.out_valid, rif.in_ready, rif.out_tag, rif.out_ox, rif.out_inv_dx, rif.out_inv_dy,
           rif.out_inv_dz, rif.out_zero, rif.out_sat} !==
          {1'b1, 1'b0, 8'h11, 32'h1, 32'h0000_4000, 32'hFFFF_8000, 32'h5555_5555, 3'b000, 3'b000}) begin
        n_bad++;
        $display("FAIL backpressure hold %0d: got v%b r%b tag %h inv %h %h %h z%b s%b want v1 r0 tag 11 inv 00004000 ffff8000 55555555 z000 s000",
                 i, rif.out_valid, rif.in_ready, rif.out_tag, rif.out_inv_dx, rif.out_inv_dy,
                 rif.out_inv_dz, rif.out_zero, rif.out_sat);
      end
    end
    @(negedge clk);
    rif.in_valid  = 1'b0;
    rif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rif.out_valid, rif.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL backpressure release: got valid %b ready %b want 0 1", rif.out_valid, rif.in_ready);
    end
    drive_ray(8'h22, 32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0003_0000);
    wait_valid(lat);
    n_cmp++;
    if ({rif.out_tag, rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz} !==
        {8'h22, 32'h0001_0000, 32'h0002_0000, 32'h0000_5555}) begin
      n_bad++;
      $display("FAIL backpressure next ray: got tag %h inv %h %h %h want 22 00010000 00020000 00005555",
               rif.out_tag, rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    bit stale;
    rif.out_ready = 1'b1;
    drive_ray(8'h77, 32'h5, 32'h6, 32'h7, 32'h0001_0000, 32'h0000_0001, 32'h0);
    // Iteration 15 runs during the cycle ending at edge k+16.
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rif.out_valid, rif.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_mid control: got valid %b ready %b want 0 1", rif.out_valid, rif.in_ready);
    end
    n_cmp++;
    if ({rif.out_tag, rif.out_inv_dx, rif.out_sat} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid data: got tag %h inv_dx %h sat %b want 0", rif.out_tag, rif.out_inv_dx, rif.out_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rif.out_valid !== 1'b0) stale = 1'b1;
    end
    n_cmp++;
    if (stale !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid stale output: got out_valid pulse %b want 0", stale);
    end
    drive_ray(8'h99, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000, 32'h8000_0000, 32'h0002_0000);
    wait_valid(lat);
    n_cmp++;
    if ({lat == 34, rif.out_tag, rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz, rif.out_sat} !==
        {1'b1, 8'h99, 32'hFFFF_0000, 32'hFFFF_FFFE, 32'h0000_8000, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_mid next ray: got lat %0d tag %h inv %h %h %h sat %b want lat 34 tag 99 inv ffff0000 fffffffe 00008000 sat 000",
               lat, rif.out_tag, rif.out_inv_dx, rif.out_inv_dy, rif.out_inv_dz, rif.out_sat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    rif.in_valid  = 1'b0;
    rif.in_tag    = '0;
    rif.in_ox     = '0;
    rif.in_oy     = '0;
    rif.in_oz     = '0;
    rif.in_dx     = '0;
    rif.in_dy     = '0;
    rif.in_dz     = '0;
    rif.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_signs();
    test_degenerate();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
